// File: rtl/htd_frame_tagger.sv
// htd_frame_tagger: tags each beat of a strobe-delimited frame with separate
// SOP/EOP bits, reports the frame length on the last beat and truncates frames
// longer than MAX_LEN with a one-cycle error pulse.
// One beat is held internally so that EOP can be decided by looking one beat ahead.
// Optional macro HTD_FRAME_CNT_EN builds a completed-frame counter on ov_frame_cnt;
// when it is undefined, ov_frame_cnt is tied to zero.
module htd_frame_tagger #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LEN    = 1518,
  parameter int LEN_WIDTH  = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [DATA_WIDTH-1:0]   iv_data,
  input  logic                    i_data_wr,
  output logic [DATA_WIDTH+1:0]   ov_data,
  output logic                    o_data_wr,
  output logic [LEN_WIDTH-1:0]    ov_frame_len,
  output logic                    o_trunc_err,
  output logic [CNT_WIDTH-1:0]    ov_frame_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRANS = 2'd1,
    DROP  = 2'd2
  } state_t;

  localparam logic [LEN_WIDTH-1:0] MAX_LEN_C = LEN_WIDTH'(MAX_LEN);

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   held_data_q, held_data_d;
  logic                    held_sop_q, held_sop_d;
  logic                    held_vld_q, held_vld_d;
  logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    wr_d_q;
  logic [DATA_WIDTH+1:0]   ov_data_q, ov_data_d;
  logic                    o_data_wr_q, o_data_wr_d;
  logic [LEN_WIDTH-1:0]    frame_len_q, frame_len_d;
  logic                    trunc_err_q, trunc_err_d;
  logic                    eop_s;
  logic                    at_max_s;

  // Next-state, capture and emission logic for the held beat.
  always_comb begin
    state_d     = state_q;
    held_data_d = held_data_q;
    held_sop_d  = held_sop_q;
    held_vld_d  = held_vld_q;
    cnt_d       = cnt_q;
    ov_data_d   = ov_data_q;
    o_data_wr_d = 1'b0;
    frame_len_d = frame_len_q;
    trunc_err_d = 1'b0;
    at_max_s    = (cnt_q == MAX_LEN_C);
    eop_s       = !i_data_wr || at_max_s;

    // The held beat leaves on this edge; the EOP decision uses the current strobe.
    if (held_vld_q) begin
      ov_data_d   = {held_sop_q, eop_s, held_data_q};
      o_data_wr_d = 1'b1;
      trunc_err_d = i_data_wr && at_max_s;
      if (eop_s) begin
        frame_len_d = cnt_q;
      end else begin
        frame_len_d = frame_len_q;
      end
    end else begin
      o_data_wr_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        held_vld_d = 1'b0;
        // Only a rising strobe starts a frame; a tail seen after reset is skipped.
        if (i_data_wr && !wr_d_q) begin
          held_data_d = iv_data;
          held_sop_d  = 1'b1;
          held_vld_d  = 1'b1;
          cnt_d       = LEN_WIDTH'(1);
          state_d     = TRANS;
        end else begin
          state_d     = IDLE;
        end
      end
      TRANS: begin
        if (!i_data_wr) begin
          held_vld_d = 1'b0;
          state_d    = IDLE;
        end else if (at_max_s) begin
          held_vld_d = 1'b0;
          state_d    = DROP;
        end else begin
          held_data_d = iv_data;
          held_sop_d  = 1'b0;
          held_vld_d  = 1'b1;
          cnt_d       = cnt_q + LEN_WIDTH'(1);
          state_d     = TRANS;
        end
      end
      DROP: begin
        held_vld_d = 1'b0;
        if (!i_data_wr) begin
          state_d = IDLE;
        end else begin
          state_d = DROP;
        end
      end
      default: begin
        held_vld_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  // State, held beat and registered outputs; wr_d resets high to ignore a frame tail.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      held_data_q <= '0;
      held_sop_q  <= 1'b0;
      held_vld_q  <= 1'b0;
      cnt_q       <= '0;
      wr_d_q      <= 1'b1;
      ov_data_q   <= '0;
      o_data_wr_q <= 1'b0;
      frame_len_q <= '0;
      trunc_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      held_data_q <= held_data_d;
      held_sop_q  <= held_sop_d;
      held_vld_q  <= held_vld_d;
      cnt_q       <= cnt_d;
      wr_d_q      <= i_data_wr;
      ov_data_q   <= ov_data_d;
      o_data_wr_q <= o_data_wr_d;
      frame_len_q <= frame_len_d;
      trunc_err_q <= trunc_err_d;
    end
  end

  assign ov_data      = ov_data_q;
  assign o_data_wr    = o_data_wr_q;
  assign ov_frame_len = frame_len_q;
  assign o_trunc_err  = trunc_err_q;

`ifdef HTD_FRAME_CNT_EN
  logic [CNT_WIDTH-1:0] frame_cnt_q;

  // Count every emitted EOP beat, truncated frames included; wraps naturally.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      frame_cnt_q <= '0;
    end else if (held_vld_q && eop_s) begin
      frame_cnt_q <= frame_cnt_q + CNT_WIDTH'(1);
    end else begin
      frame_cnt_q <= frame_cnt_q;
    end
  end

  assign ov_frame_cnt = frame_cnt_q;
`else
  assign ov_frame_cnt = '0;
`endif

endmodule

// File: tb/tb_htd_frame_tagger.sv
// Self-checking bench for htd_frame_tagger: directed frames from the test plan
// followed by randomized frame lengths, gaps and payloads. Expected output beats
// are derived per frame (length, truncation, timing) and matched in order.
module tb_htd_frame_tagger;

  localparam int DW   = 8;
  localparam int MAXL = 5;
  localparam int LW   = 8;
  localparam int CW   = 2;

  logic            clk;
  logic            rst;
  logic [DW-1:0]   data;
  logic            wr;
  logic [DW+1:0]   ov_data;
  logic            o_data_wr;
  logic [LW-1:0]   ov_frame_len;
  logic            o_trunc_err;
  logic [CW-1:0]   ov_frame_cnt;

  htd_frame_tagger #(
    .DATA_WIDTH (DW),
    .MAX_LEN    (MAXL),
    .LEN_WIDTH  (LW),
    .CNT_WIDTH  (CW)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .iv_data      (data),
    .i_data_wr    (wr),
    .ov_data      (ov_data),
    .o_data_wr    (o_data_wr),
    .ov_frame_len (ov_frame_len),
    .o_trunc_err  (o_trunc_err),
    .ov_frame_cnt (ov_frame_cnt)
  );

  typedef struct {
    int            edge_n;
    logic [DW+1:0] word;
    logic          eop;
    int            len;
    logic          trunc;
  } exp_t;

  exp_t          exp_q[$];
  int            checks   = 0;
  int            failures = 0;
  int            cyc      = 0;
  int            eop_seen = 0;
  logic [DW-1:0] fbuf [0:15];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Posedge counter used to express expected output timing.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  // Drive one frame of len beats from fbuf, then gap idle cycles; queue expectations.
  task automatic send_frame(input int len, input int gap);
    int k;
    k = (len > MAXL) ? MAXL : len;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      wr   = 1'b1;
      data = fbuf[i];
      if (i < k) begin
        exp_t e;
        e.edge_n = cyc + 2;
        e.eop    = (i == k - 1);
        e.word   = {(i == 0), e.eop, fbuf[i]};
        e.len    = k;
        e.trunc  = (len > MAXL) && (i == k - 1);
        exp_q.push_back(e);
      end
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      wr   = 1'b0;
      data = DW'($urandom);
    end
  endtask

  // Compare every DUT output beat against the next expected beat.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_data_wr) begin
        if (exp_q.size() == 0) begin
          check_val("spurious_beat", {31'd0, o_data_wr}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_val("beat_time", cyc, e.edge_n);
          check_val("ov_data", {22'd0, ov_data}, {22'd0, e.word});
          check_val("trunc_err", {31'd0, o_trunc_err}, {31'd0, e.trunc});
          if (e.eop) begin
            eop_seen++;
            check_val("frame_len", {24'd0, ov_frame_len}, e.len);
`ifdef HTD_FRAME_CNT_EN
            check_val("frame_cnt", {30'd0, ov_frame_cnt}, eop_seen % 4);
`else
            check_val("frame_cnt", {30'd0, ov_frame_cnt}, 32'd0);
`endif
          end
        end
      end else begin
        if (o_trunc_err !== 1'b0) check_val("trunc_idle", {31'd0, o_trunc_err}, 32'd0);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_data"}, {22'd0, ov_data}, 32'd0);
    check_val({tag, "_wr"}, {31'd0, o_data_wr}, 32'd0);
    check_val({tag, "_len"}, {24'd0, ov_frame_len}, 32'd0);
    check_val({tag, "_trunc"}, {31'd0, o_trunc_err}, 32'd0);
    check_val({tag, "_cnt"}, {30'd0, ov_frame_cnt}, 32'd0);
  endtask

  initial begin
    int len;
    int gap;
    rst  = 1'b1;
    wr   = 1'b0;
    data = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // 4-beat frame.
    fbuf[0] = 8'h11; fbuf[1] = 8'h22; fbuf[2] = 8'h33; fbuf[3] = 8'h44;
    send_frame(4, 2);
    // Single-beat frame.
    fbuf[0] = 8'hA5;
    send_frame(1, 2);
    // Back-to-back 2-beat frames with 1-cycle gap.
    fbuf[0] = 8'h01; fbuf[1] = 8'h02;
    send_frame(2, 1);
    fbuf[0] = 8'h03; fbuf[1] = 8'h04;
    send_frame(2, 1);
    // Exactly MAX_LEN beats, then an overlong frame, then a normal one.
    for (int i = 0; i < 16; i++) fbuf[i] = 8'h10 + 8'(i);
    send_frame(MAXL, 1);
    send_frame(MAXL + 2, 1);
    send_frame(2, 3);

    // Reset during beat 2 of a 5-beat frame, released while the strobe is high.
    repeat (3) @(negedge clk);
    @(negedge clk); wr = 1'b1; data = 8'h51;
    @(negedge clk); wr = 1'b1; data = 8'h52; rst = 1'b1;
    eop_seen = 0;
    #1 check_reset_outputs("midreset");
    @(negedge clk); wr = 1'b1; data = 8'h53; rst = 1'b0;
    @(negedge clk); wr = 1'b1; data = 8'h54;
    @(negedge clk); wr = 1'b1; data = 8'h55;
    @(negedge clk); wr = 1'b0;
    @(negedge clk);
    fbuf[0] = 8'h61; fbuf[1] = 8'h62; fbuf[2] = 8'h63;
    send_frame(3, 2);

    // Randomized frames.
    for (int f = 0; f < 60; f++) begin
      len = int'($urandom_range(1, MAXL + 3));
      gap = int'($urandom_range(1, 3));
      for (int i = 0; i < len; i++) fbuf[i] = DW'($urandom);
      send_frame(len, gap);
    end

    repeat (6) @(negedge clk);
    check_val("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
